// File: rtl/alu_seq_pkg.sv
// Shared opcode, function, internal control and state encodings for the
// sequential ALU controller.
package alu_seq_pkg;

    localparam logic [2:0] ALUOP_BNE   = 3'd1;
    localparam logic [2:0] ALUOP_RTYPE = 3'd2;
    localparam logic [2:0] ALUOP_ADDI  = 3'd3;
    localparam logic [2:0] ALUOP_SLTIU = 3'd4;
    localparam logic [2:0] ALUOP_BEQ   = 3'd5;
    localparam logic [2:0] ALUOP_LUI   = 3'd6;
    localparam logic [2:0] ALUOP_ORI   = 3'd7;

    localparam logic [5:0] FUNCT_ADD  = 6'd32;
    localparam logic [5:0] FUNCT_SUB  = 6'd34;
    localparam logic [5:0] FUNCT_AND  = 6'd36;
    localparam logic [5:0] FUNCT_OR   = 6'd37;
    localparam logic [5:0] FUNCT_SLT  = 6'd42;
    localparam logic [5:0] FUNCT_SRA  = 6'd3;
    localparam logic [5:0] FUNCT_SRAV = 6'd7;
    localparam logic [5:0] FUNCT_MULT = 6'd24;

    typedef enum logic [3:0] {
        CTRL_AND  = 4'b0000,
        CTRL_OR   = 4'b0001,
        CTRL_ADD  = 4'b0010,
        CTRL_SUB  = 4'b0110,
        CTRL_SLT  = 4'b0111,
        CTRL_SRA  = 4'b1000,
        CTRL_LUI  = 4'b1001,
        CTRL_BNE  = 4'b1010,
        CTRL_SLTU = 4'b1011,
        CTRL_MUL  = 4'b1100
    } ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq_ctrl; master drives requests and
// accepts results, slave is the ALU.
interface alu_seq_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
);
    logic               in_valid_i;
    logic               in_ready_o;
    logic [2:0]         aluop_i;
    logic [5:0]         funct_i;
    logic [DATA_W-1:0]  src1_i;
    logic [DATA_W-1:0]  src2_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [DATA_W-1:0]  result_o;
    logic               zero_o;
    logic               illegal_o;

    modport master (
        output in_valid_i, aluop_i, funct_i, src1_i, src2_i, shamt_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, zero_o, illegal_o
    );

    modport slave (
        input  in_valid_i, aluop_i, funct_i, src1_i, src2_i, shamt_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, zero_o, illegal_o
    );
endinterface

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder: aluop/funct to internal control code,
// shift-source select (1 = src1 low bits) and illegal flag. Honours ALU_SEQ_MUL_EN.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] i_aluop,
    input  logic [5:0] i_funct,
    output ctrl_e      o_ctrl,
    output logic       o_shsel,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl    = CTRL_AND;
        o_shsel   = 1'b0;
        o_illegal = 1'b0;
        case (i_aluop)
            ALUOP_BNE:   o_ctrl = CTRL_BNE;
            ALUOP_ADDI:  o_ctrl = CTRL_ADD;
            ALUOP_SLTIU: o_ctrl = CTRL_SLTU;
            ALUOP_BEQ:   o_ctrl = CTRL_SUB;
            ALUOP_LUI:   o_ctrl = CTRL_LUI;
            ALUOP_ORI:   o_ctrl = CTRL_OR;
            ALUOP_RTYPE: begin
                case (i_funct)
                    FUNCT_ADD:  o_ctrl = CTRL_ADD;
                    FUNCT_SUB:  o_ctrl = CTRL_SUB;
                    FUNCT_AND:  o_ctrl = CTRL_AND;
                    FUNCT_OR:   o_ctrl = CTRL_OR;
                    FUNCT_SLT:  o_ctrl = CTRL_SLT;
                    FUNCT_SRA:  o_ctrl = CTRL_SRA;
                    FUNCT_SRAV: begin
                        o_ctrl  = CTRL_SRA;
                        o_shsel = 1'b1;
                    end
`ifdef ALU_SEQ_MUL_EN
                    FUNCT_MULT: o_ctrl = CTRL_MUL;
`endif
                    default:    o_illegal = 1'b1;
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU with valid/ready handshake: single-cycle ops, iterative
// arithmetic shifts, optional shift-add multiply when ALU_SEQ_MUL_EN is defined.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
    input  logic      clk_i,
    input  logic      rst_i,
    alu_seq_if.slave  bus
);

    localparam int unsigned CNT_W = SHAMT_W + 1;

    state_e             r_state;
    state_e             w_next_state;
    logic [DATA_W-1:0]  r_result;
    logic               r_zero;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_cnt;

    ctrl_e              w_ctrl;
    logic               w_shsel;
    logic               w_illegal;
    logic [SHAMT_W-1:0] w_shamt;
    logic [DATA_W-1:0]  w_alu_res;
    logic               w_alu_zero;
    logic [DATA_W-1:0]  w_busy_next;
    logic               w_accept;
    logic               w_multi;

`ifdef ALU_SEQ_MUL_EN
    logic               r_is_mul;
    logic [DATA_W-1:0]  r_opa;
    logic [DATA_W-1:0]  r_opb;
`endif

    alu_seq_decode u_decode (
        .i_aluop   (bus.aluop_i),
        .i_funct   (bus.funct_i),
        .o_ctrl    (w_ctrl),
        .o_shsel   (w_shsel),
        .o_illegal (w_illegal)
    );

    assign w_shamt  = w_shsel ? bus.src1_i[SHAMT_W-1:0] : bus.shamt_i;
    assign w_accept = bus.in_valid_i && (r_state == ST_IDLE);

`ifdef ALU_SEQ_MUL_EN
    assign w_multi = !w_illegal && ((w_ctrl == CTRL_SRA && w_shamt != '0) || w_ctrl == CTRL_MUL);
    assign w_busy_next = r_is_mul ? (r_result + (r_opb[0] ? r_opa : '0))
                                  : DATA_W'($signed(r_result) >>> 1);
`else
    assign w_multi     = !w_illegal && (w_ctrl == CTRL_SRA) && (w_shamt != '0);
    assign w_busy_next = DATA_W'($signed(r_result) >>> 1);
`endif

    always_comb begin
        w_alu_res = '0;
        case (w_ctrl)
            CTRL_ADD:           w_alu_res = bus.src1_i + bus.src2_i;
            CTRL_SUB, CTRL_BNE: w_alu_res = bus.src1_i - bus.src2_i;
            CTRL_AND:           w_alu_res = bus.src1_i & bus.src2_i;
            CTRL_OR:            w_alu_res = bus.src1_i | bus.src2_i;
            CTRL_SLT:           w_alu_res[0] = $signed(bus.src1_i) < $signed(bus.src2_i);
            CTRL_SLTU:          w_alu_res[0] = bus.src1_i < bus.src2_i;
            CTRL_LUI:           w_alu_res = {bus.src2_i[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
            default:            w_alu_res = '0;
        endcase
        // bne reports branch-taken on zero_o rather than a zero result
        w_alu_zero = (w_ctrl == CTRL_BNE) ? (bus.src1_i != bus.src2_i) : (w_alu_res == '0);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state    = r_state;
        bus.in_ready_o  = 1'b0;
        bus.out_valid_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready_o = 1'b1;
                if (bus.in_valid_i) w_next_state = w_multi ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (r_cnt == CNT_W'(1)) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid_o = 1'b1;
                if (bus.out_ready_i) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_is_mul  <= 1'b0;
            r_opa     <= '0;
            r_opb     <= '0;
`endif
        end else if (w_accept) begin
            r_illegal <= w_illegal;
`ifdef ALU_SEQ_MUL_EN
            r_is_mul  <= 1'b0;
`endif
            if (w_illegal) begin
                r_result <= '0;
                r_zero   <= 1'b1;
            end else if (w_ctrl == CTRL_SRA) begin
                r_result <= bus.src2_i;
                r_zero   <= (bus.src2_i == '0);
                r_cnt    <= {1'b0, w_shamt};
`ifdef ALU_SEQ_MUL_EN
            end else if (w_ctrl == CTRL_MUL) begin
                r_result <= '0;
                r_zero   <= 1'b1;
                r_opa    <= bus.src1_i;
                r_opb    <= bus.src2_i;
                r_cnt    <= CNT_W'(DATA_W);
                r_is_mul <= 1'b1;
`endif
            end else begin
                r_result <= w_alu_res;
                r_zero   <= w_alu_zero;
            end
        end else if (r_state == ST_BUSY) begin
            r_result <= w_busy_next;
            r_zero   <= (w_busy_next == '0);
            r_cnt    <= r_cnt - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
            r_opa    <= r_opa << 1;
            r_opb    <= r_opb >> 1;
`endif
        end
    end

    assign bus.result_o  = r_result;
    assign bus.zero_o    = r_zero;
    assign bus.illegal_o = r_illegal;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: vector table through a scoreboard queue,
// plus hand sequences for backpressure/stall and reset during a shift.
module tb_alu_seq_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.DATA_W(DW), .SHAMT_W(SW)) bus ();

    alu_seq_ctrl #(.DATA_W(DW), .SHAMT_W(SW)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        illegal;
        int          busy;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] op, input logic [5:0] f,
                                input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                                input logic [31:0] r, input logic z, input logic ill, input int busy);
        vec_t v;
        v.name = n; v.aluop = op; v.funct = f; v.a = a; v.b = b; v.shamt = sh;
        v.e.result = r; v.e.zero = z; v.e.illegal = ill; v.e.busy = busy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk);
        bus.aluop_i    = v.aluop;
        bus.funct_i    = v.funct;
        bus.src1_i     = v.a;
        bus.src2_i     = v.b;
        bus.shamt_i    = v.shamt;
        bus.in_valid_i = 1'b1;
        check({v.name, ".in_ready"}, 64'(bus.in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        sb.push_back(v.e);
    endtask

    task automatic collect(input string name, input bit do_hs);
        int n = 0;
        exp_t e;
        while (bus.out_valid_o !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() == 0) begin
            check({name, ".sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check({name, ".latency"}, 64'(n), 64'(e.busy));
        check({name, ".result"}, 64'(bus.result_o), 64'(e.result));
        check({name, ".zero"}, 64'(bus.zero_o), 64'(e.zero));
        check({name, ".illegal"}, 64'(bus.illegal_o), 64'(e.illegal));
        check({name, ".in_ready_done"}, 64'(bus.in_ready_o), 64'd0);
        if (do_hs) begin
            @(negedge clk);
            bus.out_ready_i = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready_i = 1'b0;
            check({name, ".idle_valid"}, 64'(bus.out_valid_o), 64'd0);
            check({name, ".idle_ready"}, 64'(bus.in_ready_o), 64'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.aluop_i     = '0;
        bus.funct_i     = '0;
        bus.src1_i      = '0;
        bus.src2_i      = '0;
        bus.shamt_i     = '0;

        vt.push_back(mk("addi_neg",  3, 0,  32'd5,        32'hFFFF_FFF9, 0, 32'hFFFF_FFFE, 0, 0, 0));
        vt.push_back(mk("add_ovf",   2, 32, 32'h7FFF_FFFF, 32'd1,        0, 32'h8000_0000, 0, 0, 0));
        vt.push_back(mk("add_wrap",  2, 32, 32'hFFFF_FFFF, 32'd1,        0, 32'h0,         1, 0, 0));
        vt.push_back(mk("sub",       2, 34, 32'd3,        32'd5,        0, 32'hFFFF_FFFE, 0, 0, 0));
        vt.push_back(mk("and",       2, 36, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 32'h00F0_00F0, 0, 0, 0));
        vt.push_back(mk("or",        2, 37, 32'h1234_0000, 32'h0000_5678, 0, 32'h1234_5678, 0, 0, 0));
        vt.push_back(mk("slt_neg",   2, 42, 32'hFFFF_FFFF, 32'd1,        0, 32'd1,         0, 0, 0));
        vt.push_back(mk("slt_pos",   2, 42, 32'd1,        32'hFFFF_FFFF, 0, 32'd0,         1, 0, 0));
        vt.push_back(mk("sltiu_big", 4, 0,  32'hFFFF_FFFF, 32'd1,        0, 32'd0,         1, 0, 0));
        vt.push_back(mk("sltiu_sm",  4, 0,  32'd1,        32'hFFFF_FFFF, 0, 32'd1,         0, 0, 0));
        vt.push_back(mk("bne_eq",    1, 0,  32'd3,        32'd3,        0, 32'd0,         0, 0, 0));
        vt.push_back(mk("bne_ne",    1, 0,  32'd3,        32'd4,        0, 32'hFFFF_FFFF, 1, 0, 0));
        vt.push_back(mk("beq_eq",    5, 0,  32'd3,        32'd3,        0, 32'd0,         1, 0, 0));
        vt.push_back(mk("beq_ne",    5, 0,  32'd3,        32'd4,        0, 32'hFFFF_FFFF, 0, 0, 0));
        vt.push_back(mk("lui",       6, 0,  32'd0,        32'h1234_ABCD, 0, 32'hABCD_0000, 0, 0, 0));
        vt.push_back(mk("ori",       7, 0,  32'h0000_00F0, 32'h0000_000F, 0, 32'h0000_00FF, 0, 0, 0));
        vt.push_back(mk("sra4",      2, 3,  32'd0,        32'h8000_0000, 4, 32'hF800_0000, 0, 0, 4));
        vt.push_back(mk("sra1_pos",  2, 3,  32'd0,        32'h7FFF_FFFF, 1, 32'h3FFF_FFFF, 0, 0, 1));
        vt.push_back(mk("sra31",     2, 3,  32'd0,        32'h4000_0000, 31, 32'h0,        1, 0, 31));
        vt.push_back(mk("srav0",     2, 7,  32'd0,        32'h1234_5678, 7, 32'h1234_5678, 0, 0, 0));
        vt.push_back(mk("srav3",     2, 7,  32'h0000_0023, 32'h8000_0010, 9, 32'hF000_0002, 0, 0, 3));
        vt.push_back(mk("ill_op0",   0, 32, 32'd5,        32'd6,        0, 32'd0,         1, 1, 0));
        vt.push_back(mk("ill_funct", 2, 8,  32'd5,        32'd6,        0, 32'd0,         1, 1, 0));
`ifdef ALU_SEQ_MUL_EN
        vt.push_back(mk("mult",      2, 24, 32'd7,        32'd6,        0, 32'd42,        0, 0, 32));
`else
        vt.push_back(mk("mult",      2, 24, 32'd7,        32'd6,        0, 32'd0,         1, 1, 0));
`endif

        #2;
        check("rst.in_ready", 64'(bus.in_ready_o), 64'd1);
        check("rst.out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst.result", 64'(bus.result_o), 64'd0);
        check("rst.zero", 64'(bus.zero_o), 64'd0);
        check("rst.illegal", 64'(bus.illegal_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i]);
            collect(vt[i].name, 1'b1);
        end

        // Backpressure: hold DONE five cycles while a second request waits.
        drive(mk("bp_a", 3, 0, 32'd1, 32'd1, 0, 32'd2, 0, 0, 0));
        collect("bp_a", 1'b0);
        @(negedge clk);
        bus.aluop_i = 3'd7; bus.src1_i = 32'h10; bus.src2_i = 32'h01; bus.in_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp.hold_valid", 64'(bus.out_valid_o), 64'd1);
            check("bp.hold_result", 64'(bus.result_o), 64'd2);
            check("bp.hold_ready", 64'(bus.in_ready_o), 64'd0);
        end
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        check("bp.after_hs_ready", 64'(bus.in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        sb.push_back('{result: 32'h11, zero: 1'b0, illegal: 1'b0, busy: 0});
        collect("bp_b", 1'b1);

        // Reset in the middle of a 20-step shift.
        begin
            int seen = 0;
            drive(mk("rst_sra20", 2, 3, 32'd0, 32'h8000_0000, 20, 32'hFFFF_F800, 0, 0, 20));
            repeat (5) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("midrst.in_ready", 64'(bus.in_ready_o), 64'd1);
            check("midrst.out_valid", 64'(bus.out_valid_o), 64'd0);
            check("midrst.result", 64'(bus.result_o), 64'd0);
            check("midrst.zero", 64'(bus.zero_o), 64'd0);
            check("midrst.illegal", 64'(bus.illegal_o), 64'd0);
            sb.delete();
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk);
                #1;
                if (bus.out_valid_o === 1'b1) seen++;
            end
            check("midrst.no_output", 64'(seen), 64'd0);
        end

        drive(mk("post_rst_add", 2, 32, 32'd40, 32'd2, 0, 32'd42, 0, 0, 0));
        collect("post_rst_add", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; legal values 8..64, powers of two.
REQ-002 SHALL have parameter SHAMT_W, default $clog2(DATA_W), shift-amount width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid_i  input  1  request valid.
REQ-006 SHALL have port in_ready_o  output  1  block can accept a request.
REQ-007 SHALL have port aluop_i  input  3  opcode class: 1 bne, 2 R-type, 3 addi, 4 sltiu, 5 beq, 6 lui, 7 ori.
REQ-008 SHALL have port funct_i  input  6  R-type function: 32 add, 34 sub, 36 and, 37 or, 42 slt, 3 sra, 7 srav.
REQ-009 SHALL have port src1_i  input  DATA_W  operand A (rs).
REQ-010 SHALL have port src2_i  input  DATA_W  operand B (rt or extended immediate).
REQ-011 SHALL have port shamt_i  input  SHAMT_W  immediate shift amount.
REQ-012 SHALL have port out_valid_o  output  1  result valid.
REQ-013 SHALL have port out_ready_i  input  1  consumer accepts result.
REQ-014 SHALL have ports result_o  output  DATA_W, zero_o  output  1, illegal_o  output  1.

Function
REQ-015 SHALL implement states IDLE, BUSY, DONE; in_ready_o=1 only in IDLE; out_valid_o=1 only in DONE.
REQ-016 SHALL capture operands, decoded op and shift count when in_valid_i&in_ready_o; inputs ignored otherwise.
REQ-017 Single-cycle ops (add, sub, and, or, slt, addi, sltiu, beq, bne, lui, ori) SHALL go IDLE->DONE; result_o valid the cycle after acceptance.
REQ-018 slt SHALL compare signed, sltiu unsigned; result 1 or 0 zero-extended to DATA_W.
REQ-019 add/sub/addi SHALL wrap modulo 2^DATA_W; no overflow flag.
REQ-020 lui SHALL produce {src2_i[DATA_W/2-1:0], DATA_W/2 zeros}; ori SHALL produce src1_i|src2_i.
REQ-021 zero_o SHALL equal (result_o==0) for all ops except bne, where zero_o=(src1_i!=src2_i), i.e. branch-taken.
REQ-022 sra SHALL shift src2_i right arithmetically by shamt_i; srav by src1_i[SHAMT_W-1:0].
REQ-023 Shifts SHALL be iterative, one bit per cycle in BUSY; count N costs N BUSY cycles, then DONE; N=0 goes IDLE->DONE directly.
REQ-024 Unlisted aluop_i (0) or funct_i SHALL go IDLE->DONE with result_o=0, zero_o=1, illegal_o=1; illegal_o=0 for legal ops.
REQ-025 DONE SHALL hold result_o, zero_o, illegal_o stable until out_ready_i=1; then go to IDLE next edge.
REQ-026 Request in_valid_i while in BUSY/DONE SHALL be stalled (in_ready_o=0), not dropped by the block.
REQ-027 Max throughput: one result per 2 cycles for single-cycle ops.

Reset
REQ-028 rst_i=0 SHALL immediately force IDLE, in_ready_o=1, out_valid_o=0, result_o=0, zero_o=0, illegal_o=0, shift count 0.
REQ-029 Reset during BUSY or DONE SHALL discard the operation with no output produced after release.

Configuration
REQ-030 Macro ALU_SEQ_MUL_EN defined: funct 24 (mult) SHALL produce low DATA_W bits of unsigned product via shift-add, exactly DATA_W BUSY cycles.
REQ-031 ALU_SEQ_MUL_EN undefined: funct 24 SHALL be treated as illegal per REQ-024; no multiplier logic present.

Structure
REQ-032 Package alu_seq_pkg SHALL hold aluop codes, funct codes, internal ctrl codes (add 0010, sub 0110, and 0000, or 0001, slt 0111, sra 1000, lui 1001, bne 1010, sltu 1011, mul 1100) and state enum.
REQ-033 Combinational sub-module alu_seq_decode SHALL map aluop_i/funct_i to ctrl code, shift-source select and illegal flag.

Verification
REQ-034 addi src1=5, src2=-7 -> one cycle later out_valid_o=1, result_o=0xFFFFFFFE, zero_o=0.
REQ-035 sra src2=0x80000000, shamt=4 -> 4 BUSY cycles, result_o=0xF8000000; srav with src1=0 -> immediate DONE, result=src2.
REQ-036 slt -1 vs 1 -> 1; sltiu 0xFFFFFFFF vs 1 -> 0; bne 3 vs 3 -> zero_o=0; beq 3 vs 3 -> zero_o=1.
REQ-037 out_ready_i held 0 for 5 cycles in DONE -> outputs stable, in_ready_o=0; new request accepted only after handshake.
REQ-038 rst_i asserted mid-BUSY of 20-bit shift -> outputs reset immediately, no out_valid_o after release.
REQ-039 aluop=2 funct=24 -> with ALU_SEQ_MUL_EN, 7*6 gives 42 after 32 BUSY cycles; without, illegal_o=1, result_o=0.
